// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared definitions for the serial CLA add/subtract unit.
// Holds the controller state encoding and the width of the shared
// carry-lookahead slice. Files that need these import
// cla_serial_add_ctrl_pkg::*.
package cla_serial_add_ctrl_pkg;

   // Width of the one CLA slice that every operation is sequenced through
   localparam int NIBBLE_W = 4;

   // Controller states: waiting for operands, stepping nibbles, holding the result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_serial_add_ctrl_if.sv
// Handshake and data bundle for the serial CLA add/subtract unit.
// Operand side : in_valid/in_ready, a, b, cin, op_sub
// Result side  : out_valid/out_ready, sum, cout, ovf
// Status       : busy (an operation is in flight or its result is waiting)
// The slave modport is the adder's view; master is the requester/consumer's view.
interface cla_serial_add_ctrl_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, op_sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, cin, op_sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );

endinterface

// File: rtl/cla_serial_add_ctrl_fa4.sv
// FA_4bits: purely combinational 4-bit carry-lookahead adder slice.
// Ports: a, b (4-bit addends), cin (carry in) -> sum (4-bit), carry (carry out).
// All four internal carries are formed directly from generate/propagate
// terms, so the slice has no ripple path between its bits.
module FA_4bits
   import cla_serial_add_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                carry
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   // Generate/propagate per bit, then flattened lookahead carry equations
   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum   = p ^ c[NIBBLE_W-1:0];
   assign carry = c[NIBBLE_W];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: multi-cycle WIDTH-bit add/subtract built on one
// shared 4-bit CLA slice, processed one nibble per cycle, LSB first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - slave side of cla_serial_add_ctrl_if (operand handshake,
//           result handshake, sum/cout/ovf, busy)
// Subtraction is done as a + ~b + 1: b is inverted when latched and the
// carry register is seeded with 1, so the slice only ever adds.
module cla_serial_add_ctrl
   import cla_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cla_serial_add_ctrl_if.slave  bus
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIB - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    idx;
   logic                carry;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic [WIDTH-1:0]    sum_r;
   logic                cout_r;
   logic                ovf_r;
   logic                accept;
   logic                step;
   logic                last;
   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_carry;

   // The slice always sees the nibble selected by idx plus the running carry
   assign slice_a = a_r[NIBBLE_W*idx +: NIBBLE_W];
   assign slice_b = b_r[NIBBLE_W*idx +: NIBBLE_W];
   assign last    = (idx == LAST_IDX);

   FA_4bits u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .cin   (carry),
      .sum   (slice_sum),
      .carry (slice_carry)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; operands are only taken in IDLE and
   // the result is held in DONE until the consumer takes it
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      accept        = 1'b0;
      step          = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            step     = 1'b1;
            if (last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, then write one sum nibble per RUN
   // cycle. idx stops at the last nibble instead of wrapping; the final pass
   // also captures cout and the signed overflow from the top sum bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         idx    <= '0;
         carry  <= bus.op_sub ? 1'b1 : bus.cin;
         a_r    <= bus.a;
         b_r    <= bus.op_sub ? ~bus.b : bus.b;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (step) begin
         sum_r[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
         carry <= slice_carry;
         if (last) begin
            cout_r <= slice_carry;
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                      (slice_sum[NIBBLE_W-1] != a_r[WIDTH-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;

endmodule
